// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA timing defaults, raster length helpers and colour-bar table
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam bit          DEF_HS_POL   = 1'b0;
  localparam bit          DEF_VS_POL   = 1'b0;
  localparam int unsigned DEF_CW       = 4;

  function automatic int unsigned h_tot(input int unsigned act, input int unsigned fp,
                                        input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned v_tot(input int unsigned act, input int unsigned fp,
                                        input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  // {r,g,b} channel enables per bar, left to right
  localparam logic [2:0] BAR_RGB [8] = '{3'b000, 3'b001, 3'b010, 3'b011,
                                         3'b100, 3'b101, 3'b110, 3'b111};

endpackage

// File: rtl/vga_axis_cnt.sv
// rtl/vga_axis_cnt.sv - one raster axis: position counter with active/sync region decode
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter int unsigned W      = $clog2(ACTIVE + FP + SYNC + BP)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         carry_o,
  output logic         active_o,
  output logic         sync_o
);

  localparam int unsigned TOT        = ACTIVE + FP + SYNC + BP;
  localparam int unsigned SYNC_START = ACTIVE + FP;

  logic [W-1:0] cnt_q, cnt_d;
  logic         last;

  assign last = (cnt_q == W'(TOT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = last ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o    = cnt_q;
  assign carry_o  = en_i & last;
  assign active_o = (cnt_q < W'(ACTIVE));
  assign sync_o   = (cnt_q >= W'(SYNC_START)) && (cnt_q < W'(SYNC_START + SYNC));

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA timing generator with a two-stage frame-buffer read pipeline
// Define VGA_TESTPAT_EN to add the tp_sel colour-bar test pattern.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = DEF_HS_POL,
  parameter bit          VS_POL   = DEF_VS_POL,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pix_en,
`ifdef VGA_TESTPAT_EN
  input  logic                        tp_sel,
`endif
  input  logic [3*CW-1:0]             din,
  output logic [$clog2(V_ACTIVE)-1:0] row,
  output logic [$clog2(H_ACTIVE)-1:0] col,
  output logic                        rdn,
  output logic [CW-1:0]               r,
  output logic [CW-1:0]               g,
  output logic [CW-1:0]               b,
  output logic                        hs,
  output logic                        vs,
  output logic                        de,
  output logic                        frame_start,
  output logic                        line_start
);

  localparam int unsigned HW  = $clog2(h_tot(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int unsigned VW  = $clog2(v_tot(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int unsigned CLW = $clog2(H_ACTIVE);
  localparam int unsigned RW  = $clog2(V_ACTIVE);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          h_carry, v_carry, h_act, v_act, h_sync, v_sync, rd_req;

  vga_axis_cnt #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HW)) u_hcnt (
    .clk(clk), .rst(rst), .en_i(pix_en), .cnt_o(hcnt), .carry_o(h_carry),
    .active_o(h_act), .sync_o(h_sync)
  );

  vga_axis_cnt #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VW)) u_vcnt (
    .clk(clk), .rst(rst), .en_i(h_carry), .cnt_o(vcnt), .carry_o(v_carry),
    .active_o(v_act), .sync_o(v_sync)
  );

  // sof_q marks that the counters currently sit at (0,0)
  logic           sof_q, sof_d;
  logic [CLW-1:0] col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic           rdn_q, rdn_d, hsy_q, hsy_d, vsy_q, vsy_d, sol_q, sol_d, fs1_q, fs1_d;
  logic [CW-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic           hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d, ls_q, ls_d;
`ifdef VGA_TESTPAT_EN
  logic           tp_q, tp_d;
  logic [2:0]     bar_q, bar_d;

  assign rd_req = h_act & v_act & ~tp_sel;
`else
  assign rd_req = h_act & v_act;
`endif

  always_comb begin
    sof_d = v_carry;
    col_d = rd_req ? CLW'(hcnt) : col_q;
    row_d = rd_req ? RW'(vcnt) : row_q;
    rdn_d = ~rd_req;
    hsy_d = h_sync;
    vsy_d = v_sync;
    sol_d = (hcnt == '0);
    fs1_d = sof_q;
    hs_d  = hsy_q ? HS_POL : ~HS_POL;
    vs_d  = vsy_q ? VS_POL : ~VS_POL;
    ls_d  = sol_q;
    fs_d  = fs1_q;
    de_d  = ~rdn_q;
    {b_d, g_d, r_d} = rdn_q ? '0 : din;
`ifdef VGA_TESTPAT_EN
    tp_d  = h_act & v_act & tp_sel;
    bar_d = BAR_RGB[3'(hcnt / HW'(H_ACTIVE / 8))];
    if (tp_q) begin
      de_d = 1'b1;
      r_d  = {CW{bar_q[2]}};
      g_d  = {CW{bar_q[1]}};
      b_d  = {CW{bar_q[0]}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sof_q <= 1'b1;
      col_q <= '0;
      row_q <= '0;
      rdn_q <= 1'b1;
      hsy_q <= 1'b0;
      vsy_q <= 1'b0;
      sol_q <= 1'b0;
      fs1_q <= 1'b0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      de_q  <= 1'b0;
      fs_q  <= 1'b0;
      ls_q  <= 1'b0;
`ifdef VGA_TESTPAT_EN
      tp_q  <= 1'b0;
      bar_q <= '0;
`endif
    end else if (pix_en) begin
      sof_q <= sof_d;
      col_q <= col_d;
      row_q <= row_d;
      rdn_q <= rdn_d;
      hsy_q <= hsy_d;
      vsy_q <= vsy_d;
      sol_q <= sol_d;
      fs1_q <= fs1_d;
      r_q   <= r_d;
      g_q   <= g_d;
      b_q   <= b_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      fs_q  <= fs_d;
      ls_q  <= ls_d;
`ifdef VGA_TESTPAT_EN
      tp_q  <= tp_d;
      bar_q <= bar_d;
`endif
    end
  end

  assign row         = row_q;
  assign col         = col_q;
  assign rdn         = rdn_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - directed bench for vga_timing_ctrl on a reduced 24x13 raster
// Raster: H 16/2/3/3 (sync x=18..20), V 8/1/2/2 (sync y=9..10), HS_POL=0, VS_POL=1.
module tb_vga_timing_ctrl;

  localparam logic [11:0] D = 12'hA53;

  logic        clk    = 1'b0;
  logic        rst    = 1'b0;
  logic        pix_en = 1'b0;
  logic [11:0] din    = '0;
  logic [3:0]  col;
  logic [2:0]  row;
  logic        rdn;
  logic [3:0]  r, g, b;
  logic        hs, vs, de, frame_start, line_start;
`ifdef VGA_TESTPAT_EN
  logic        tp_sel = 1'b0;
`endif

  int checks = 0;
  int fails  = 0;

  vga_timing_ctrl #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b1), .CW(4)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
`ifdef VGA_TESTPAT_EN
    .tp_sel(tp_sel),
`endif
    .din(din), .row(row), .col(col), .rdn(rdn), .r(r), .g(g), .b(b),
    .hs(hs), .vs(vs), .de(de), .frame_start(frame_start), .line_start(line_start)
  );

  always #5 clk = ~clk;

  // k = pix_en edges after reset release; fl = {hs,vs,de,frame_start,line_start}
  typedef struct {
    int          k;
    logic [11:0] din;
    logic [3:0]  col;
    logic [2:0]  row;
    logic        rdn;
    logic [11:0] bgr;
    logic [4:0]  fl;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input int k, input logic [11:0] d, input logic [3:0] c,
                              input logic [2:0] rw, input logic rd, input logic [11:0] bgr,
                              input logic [4:0] fl);
    vec_t v;
    v.k = k; v.din = d; v.col = c; v.row = rw; v.rdn = rd; v.bgr = bgr; v.fl = fl;
    return v;
  endfunction

  function automatic logic [4:0] flags();
    return {hs, vs, de, frame_start, line_start};
  endfunction

  function automatic logic [24:0] snap();
    return {row, col, rdn, b, g, r, hs, vs, de, frame_start, line_start};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, ".col"}, 32'(col), 0);
    chk({pfx, ".row"}, 32'(row), 0);
    chk({pfx, ".rdn"}, 32'(rdn), 1);
    chk({pfx, ".bgr"}, 32'({b, g, r}), 0);
    chk({pfx, ".flags"}, 32'(flags()), 32'(5'b10000));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pix_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  int frame_hs, frame_vs, frame_de, frame_bad, frame_fs, frame_ls;
  int frozen_bad, rise1, rise2;
  logic [24:0] prev, cur;

  initial begin
    vq.push_back(mk(1,   D,        0,  0, 0, 12'h000, 5'b10000));
    vq.push_back(mk(2,   D,        1,  0, 0, D,       5'b10111));
    vq.push_back(mk(3,   D,        2,  0, 0, D,       5'b10100));
    vq.push_back(mk(5,   12'h0F1,  4,  0, 0, 12'h0F1, 5'b10100));
    vq.push_back(mk(17,  D,        15, 0, 1, D,       5'b10100));
    vq.push_back(mk(18,  D,        15, 0, 1, 12'h000, 5'b10000));
    vq.push_back(mk(20,  D,        15, 0, 1, 12'h000, 5'b00000));
    vq.push_back(mk(22,  D,        15, 0, 1, 12'h000, 5'b00000));
    vq.push_back(mk(23,  D,        15, 0, 1, 12'h000, 5'b10000));
    vq.push_back(mk(26,  D,        1,  1, 0, D,       5'b10101));
    vq.push_back(mk(184, D,        15, 7, 0, D,       5'b10100));
    vq.push_back(mk(185, D,        15, 7, 1, D,       5'b10100));
    vq.push_back(mk(218, D,        15, 7, 1, 12'h000, 5'b11001));
    vq.push_back(mk(238, D,        15, 7, 1, 12'h000, 5'b01000));
    vq.push_back(mk(242, D,        15, 7, 1, 12'h000, 5'b11001));
    vq.push_back(mk(266, D,        15, 7, 1, 12'h000, 5'b10001));
    vq.push_back(mk(313, D,        0,  0, 0, 12'h000, 5'b10000));
    vq.push_back(mk(314, D,        1,  0, 0, D,       5'b10111));

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b1;

    foreach (vq[i]) begin
      do_reset();
      din = vq[i].din;
      pix_en = 1'b1;
      repeat (vq[i].k) @(posedge clk);
      #1;
      pix_en = 1'b0;
      chk($sformatf("v%0d.col", i),   32'(col),       32'(vq[i].col));
      chk($sformatf("v%0d.row", i),   32'(row),       32'(vq[i].row));
      chk($sformatf("v%0d.rdn", i),   32'(rdn),       32'(vq[i].rdn));
      chk($sformatf("v%0d.bgr", i),   32'({b, g, r}), 32'(vq[i].bgr));
      chk($sformatf("v%0d.flags", i), 32'(flags()),   32'(vq[i].fl));
    end

    // two full frames, stage-2 positions 0..623
    do_reset();
    din = D;
    pix_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    frame_hs = 0; frame_vs = 0; frame_de = 0; frame_bad = 0; frame_fs = 0; frame_ls = 0;
    for (int i = 0; i < 624; i++) begin
      if (!hs) frame_hs++;
      if (vs) frame_vs++;
      if (de) frame_de++;
      if (frame_start) frame_fs++;
      if (line_start) frame_ls++;
      if (de ? ({b, g, r} !== D) : ({b, g, r} !== 12'h000)) frame_bad++;
      @(posedge clk);
      #1;
    end
    pix_en = 1'b0;
    chk("frames.hs_low",      32'(frame_hs),  78);
    chk("frames.vs_active",   32'(frame_vs),  96);
    chk("frames.de_count",    32'(frame_de),  256);
    chk("frames.rgb_vs_de",   32'(frame_bad), 0);
    chk("frames.frame_start", 32'(frame_fs),  2);
    chk("frames.line_start",  32'(frame_ls),  26);

    // pix_en toggling 1,0
    do_reset();
    din = D;
    prev = snap();
    frozen_bad = 0; rise1 = -1; rise2 = -1;
    for (int i = 0; i < 200; i++) begin
      pix_en = (i % 2 == 0);
      @(posedge clk);
      #1;
      cur = snap();
      if (!pix_en && cur !== prev) frozen_bad++;
      if (cur[0] && !prev[0]) begin
        if (rise1 < 0) rise1 = i;
        else if (rise2 < 0) rise2 = i;
      end
      prev = cur;
    end
    pix_en = 1'b0;
    chk("toggle.frozen",      32'(frozen_bad),    0);
    chk("toggle.line_period", 32'(rise2 - rise1), 48);

    // asynchronous reset mid-line at counter (10,3)
    do_reset();
    din = D;
    pix_en = 1'b1;
    repeat (82) @(posedge clk);
    #1;
    chk("midrst.pre_col", 32'(col), 9);
    chk("midrst.pre_de",  32'(de),  1);
    #2 rst = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst.e1_fs",  32'(frame_start), 0);
    chk("midrst.e1_col", 32'(col),         0);
    chk("midrst.e1_rdn", 32'(rdn),         0);
    @(posedge clk); #1;
    chk("midrst.e2_fs",  32'(frame_start), 1);
    chk("midrst.e2_ls",  32'(line_start),  1);
    pix_en = 1'b0;

`ifdef VGA_TESTPAT_EN
    do_reset();
    tp_sel = 1'b1;
    din = D;
    pix_en = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("tp.x0_bgr", 32'({b, g, r}), 0);
    chk("tp.x0_rdn", 32'(rdn), 1);
    repeat (2) @(posedge clk); #1;
    chk("tp.x2_bgr", 32'({b, g, r}), 32'h0F00);
    repeat (12) @(posedge clk); #1;
    chk("tp.x14_bgr", 32'({b, g, r}), 32'h0FFF);
    chk("tp.x14_rdn", 32'(rdn), 1);
    pix_en = 1'b0;
    tp_sel = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
